// File: rtl/trig_capture_ram_pkg.sv
// rtl/trig_capture_ram_pkg.sv - shared state encoding and address-width helper
package trig_capture_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_READ
    } state_t;

    function automatic int addr_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/trig_capture_ram_if.sv
// rtl/trig_capture_ram_if.sv - readout stream between capture buffer and consumer
interface trig_capture_ram_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] rd_data;
    logic             data_vaild;
    logic             rd_ready;
    logic             data_tlast;

    modport master (output rd_data, data_vaild, data_tlast, input rd_ready);
    modport slave  (input rd_data, data_vaild, data_tlast, output rd_ready);
endinterface

// File: rtl/trig_capture_sdpram.sv
// rtl/trig_capture_sdpram.sv - simple dual-port RAM, one write port, registered read port
module trig_capture_sdpram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 24,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/trig_capture_ram.sv
// rtl/trig_capture_ram.sv - pre/post trigger capture into circular RAM with streamed readout
module trig_capture_ram
    import trig_capture_ram_pkg::*;
#(
    parameter int RAM_DEEP   = 2048,
    parameter int DATA_WIDTH = 12,
    parameter int CH_NUM     = 2,
    parameter int PRE_DEEP   = 512
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CH_NUM*DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_valid,
    input  logic                         Request,
    input  logic                         trig,
    output logic                         busy,
    trig_capture_ram_if.master           rd
);
    localparam int AW  = addr_width(RAM_DEEP);
    localparam int AW1 = AW + 1;
    localparam int W   = CH_NUM * DATA_WIDTH;
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_DEEP);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEEP - 1);
    localparam logic [AW-1:0] BEAT_LAST = AW'(RAM_DEEP - 1);
    localparam logic [AW:0]   POST_LAST = AW1'(RAM_DEEP - PRE_DEEP - 1);

    state_t        state;
    logic [AW-1:0] wa, pre_cnt, trig_addr, ra, rd_cnt;
    logic [AW:0]   post_cnt;
    logic          trig_prev, rd_done;
    logic          infl, infl_last;
    logic [W-1:0]  ram_q, b0_data, b1_data;
    logic          b0_last, b1_last;
    logic [1:0]    fill, occ;
    logic          wr_en, pop, issue, trig_edge;

    assign wr_en     = wr_valid && (state == ST_PRE || state == ST_ARMED || state == ST_POST);
    assign trig_edge = trig && !trig_prev;
    assign pop       = (fill != 2'd0) && rd.rd_ready;
    // Reads in flight plus buffered beats never exceed the two skid entries.
    assign occ       = fill + {1'b0, infl};
    assign issue     = (state == ST_READ) && !rd_done && ((occ < 2'd2) || pop);

    assign rd.rd_data    = b0_data;
    assign rd.data_vaild = (fill != 2'd0);
    assign rd.data_tlast = b0_last && (fill != 2'd0);

    trig_capture_sdpram #(
        .DEPTH (RAM_DEEP),
        .WIDTH (W),
        .AW    (AW)
    ) u_ram (
        .clk (clk),
        .we  (wr_en),
        .wa  (wa),
        .wd  (wr_data),
        .re  (issue),
        .ra  (ra),
        .rd  (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            wa        <= '0;
            pre_cnt   <= '0;
            trig_addr <= '0;
            ra        <= '0;
            rd_cnt    <= '0;
            post_cnt  <= '0;
            trig_prev <= 1'b0;
            rd_done   <= 1'b0;
            infl      <= 1'b0;
            infl_last <= 1'b0;
            b0_data   <= '0;
            b1_data   <= '0;
            b0_last   <= 1'b0;
            b1_last   <= 1'b0;
            fill      <= 2'd0;
        end else begin
            infl <= issue;
            if (issue) begin
                ra        <= ra + 1'b1;
                rd_cnt    <= rd_cnt + 1'b1;
                infl_last <= (rd_cnt == BEAT_LAST);
                if (rd_cnt == BEAT_LAST) rd_done <= 1'b1;
            end

            case ({infl, pop})
                2'b10: begin
                    if (fill == 2'd0) begin
                        b0_data <= ram_q;
                        b0_last <= infl_last;
                        fill    <= 2'd1;
                    end else begin
                        b1_data <= ram_q;
                        b1_last <= infl_last;
                        fill    <= 2'd2;
                    end
                end
                2'b01: begin
                    b0_data <= b1_data;
                    b0_last <= b1_last;
                    fill    <= fill - 2'd1;
                end
                2'b11: begin
                    if (fill == 2'd1) begin
                        b0_data <= ram_q;
                        b0_last <= infl_last;
                    end else begin
                        b0_data <= b1_data;
                        b0_last <= b1_last;
                        b1_data <= ram_q;
                        b1_last <= infl_last;
                    end
                end
                default: ;
            endcase

            case (state)
                ST_IDLE: begin
                    if (Request) begin
                        wa        <= '0;
                        pre_cnt   <= '0;
                        post_cnt  <= '0;
                        trig_prev <= 1'b0;
                        rd_cnt    <= '0;
                        rd_done   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (PRE_DEEP == 0) ? ST_ARMED : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (wr_valid) begin
                        wa        <= wa + 1'b1;
                        pre_cnt   <= pre_cnt + 1'b1;
                        trig_prev <= trig;
                        if (pre_cnt == PRE_LAST) state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (wr_valid) begin
                        wa        <= wa + 1'b1;
                        trig_prev <= trig;
                        if (trig_edge) begin
                            trig_addr <= wa;
                            ra        <= wa - PRE_OFS;
                            post_cnt  <= AW1'(1);
                            state     <= (POST_LAST == '0) ? ST_READ : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (wr_valid) begin
                        wa       <= wa + 1'b1;
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt == POST_LAST) begin
                            ra    <= trig_addr - PRE_OFS;
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (pop && b0_last) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trig_capture_ram.sv
// tb/tb_trig_capture_ram.sv - scoreboard bench for trig_capture_ram (PRE_DEEP 4 and 0 instances)
module tb_trig_capture_ram;
    localparam int DEPTH = 16;
    localparam int W     = 24;
    localparam int NS    = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n [2];
    logic [W-1:0] wd    [2];
    logic         wv    [2];
    logic         req   [2];
    logic         trg   [2];
    logic         rdy   [2] = '{1'b1, 1'b1};
    int           rmode [2] = '{0, 0};
    int           rcnt  [2] = '{0, 0};
    wire          busy_a, busy_b;

    trig_capture_ram_if #(.WIDTH(W)) ia ();
    trig_capture_ram_if #(.WIDTH(W)) ib ();
    assign ia.rd_ready = rdy[0];
    assign ib.rd_ready = rdy[1];

    trig_capture_ram #(.RAM_DEEP(DEPTH), .DATA_WIDTH(12), .CH_NUM(2), .PRE_DEEP(4)) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .wr_data(wd[0]), .wr_valid(wv[0]),
        .Request(req[0]), .trig(trg[0]), .busy(busy_a), .rd(ia)
    );
    trig_capture_ram #(.RAM_DEEP(DEPTH), .DATA_WIDTH(12), .CH_NUM(2), .PRE_DEEP(0)) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .wr_data(wd[1]), .wr_valid(wv[1]),
        .Request(req[1]), .trig(trg[1]), .busy(busy_b), .rd(ib)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] vals [NS];
    logic         tp   [NS];
    logic [W:0]   q0 [$];
    logic [W:0]   q1 [$];

    function automatic void qpush(input int d, input logic [W:0] e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endfunction
    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction
    function automatic logic [W:0] qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic get_valid(input int d);
        return (d == 0) ? ia.data_vaild : ib.data_vaild;
    endfunction
    function automatic logic get_last(input int d);
        return (d == 0) ? ia.data_tlast : ib.data_tlast;
    endfunction
    function automatic logic [W-1:0] get_data(input int d);
        return (d == 0) ? ia.rd_data : ib.rd_data;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // First rising edge of trig over valid samples, looked for only once the pre-trigger window is full.
    function automatic int find_trig(input int pre);
        for (int k = pre; k < NS; k++)
            if (tp[k] && !(k > 0 && tp[k-1])) return k;
        return -1;
    endfunction

    logic         stall_q    [2] = '{1'b0, 1'b0};
    logic [W-1:0] stall_data [2];

    task automatic mon(input int d);
        logic         v, r, l;
        logic [W-1:0] dat;
        logic [W:0]   e;
        v   = get_valid(d);
        r   = rdy[d];
        l   = get_last(d);
        dat = get_data(d);
        if (!rst_n[d]) begin
            stall_q[d] = 1'b0;
            return;
        end
        if (stall_q[d]) begin
            checks++;
            if (!v || dat !== stall_data[d]) begin
                errors++;
                $display("FAIL hold dut%0d: valid=%0b data=%0h required valid=1 data=%0h", d, v, dat, stall_data[d]);
            end
        end
        if (v && r) begin
            checks++;
            if (qsize(d) == 0) begin
                errors++;
                $display("FAIL extra_beat dut%0d: data=%0h last=%0b required no beat", d, dat, l);
            end else begin
                e = qpop(d);
                if (dat !== e[W-1:0] || l !== e[W]) begin
                    errors++;
                    $display("FAIL beat dut%0d: data=%0h last=%0b required data=%0h last=%0b", d, dat, l, e[W-1:0], e[W]);
                end
            end
        end
        stall_q[d]    = v && !r;
        stall_data[d] = dat;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            case (rmode[d])
                1:       rdy[d] = (rcnt[d] % 4 == 0) || (rcnt[d] % 4 == 3);
                2:       rdy[d] = 1'($urandom_range(0, 1));
                default: rdy[d] = 1'b1;
            endcase
            rcnt[d]++;
        end
    end

    task automatic set_directed(input int lo, input int hi, input bit pre_high);
        for (int k = 0; k < NS; k++) begin
            vals[k] = W'(k);
            tp[k]   = (k >= lo && k < hi) || (pre_high && k < 4);
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < NS; k++) begin
            vals[k] = W'($urandom);
            tp[k]   = (k < 99) ? ($urandom_range(0, 5) == 0) : 1'b0;
        end
        tp[100] = 1'b1;
    endtask

    // vmode: 0 continuous, 1 every third cycle, 2 random; abort_after >= 0 resets that many samples after trigger
    task automatic run_capture(input int d, input int pre, input int vmode, input int abort_after);
        int  kt, k, cyc;
        bit  valid;
        kt = find_trig(pre);
        if (abort_after < 0)
            for (int i = 0; i < DEPTH; i++) qpush(d, {(i == DEPTH - 1), vals[kt - pre + i]});
        @(posedge clk); #1;
        req[d] = 1'b1;
        wv[d]  = 1'b0;
        @(posedge clk); #1;
        req[d] = 1'b0;
        k   = 0;
        cyc = 0;
        forever begin
            if (abort_after >= 0 && k == kt + abort_after + 1) begin
                wv[d]    = 1'b0;
                rst_n[d] = 1'b0;
                @(posedge clk); #1;
                rst_n[d] = 1'b1;
                @(negedge clk);
                chk("abort_busy", W'(get_busy(d)), W'(0));
                chk("abort_valid", W'(get_valid(d)), W'(0));
                return;
            end
            case (vmode)
                0:       valid = 1'b1;
                1:       valid = (cyc % 3 == 0);
                default: valid = ($urandom_range(0, 2) != 0);
            endcase
            if (valid && k < NS) begin
                wv[d]  = 1'b1;
                wd[d]  = vals[k];
                trg[d] = tp[k];
                k++;
            end else begin
                wv[d]  = 1'b0;
                wd[d]  = W'($urandom);
                trg[d] = 1'($urandom_range(0, 1));
            end
            req[d] = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc++;
            @(negedge clk);
            if (!get_busy(d)) break;
            if (cyc > 4000) begin
                checks++;
                errors++;
                $display("FAIL timeout dut%0d: busy still 1 after %0d cycles, required capture end", d, cyc);
                break;
            end
            @(posedge clk); #1;
        end
        req[d] = 1'b0;
        wv[d]  = 1'b0;
        trg[d] = 1'b0;
        chk("end_valid", W'(get_valid(d)), W'(0));
        chk("end_queue", W'(qsize(d)), W'(0));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            wd[d]    = '0;
            wv[d]    = 1'b0;
            req[d]   = 1'b0;
            trg[d]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", W'(get_busy(d)), W'(0));
            chk("reset_valid", W'(get_valid(d)), W'(0));
            chk("reset_last", W'(get_last(d)), W'(0));
            chk("reset_data", get_data(d), W'(0));
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        set_directed(20, 23, 1'b0);
        run_capture(0, 4, 0, -1);

        set_directed(9, 12, 1'b1);
        run_capture(0, 4, 0, -1);

        set_directed(20, 23, 1'b0);
        rmode[0] = 1;
        run_capture(0, 4, 0, -1);
        rmode[0] = 0;

        set_directed(3, 5, 1'b0);
        run_capture(1, 0, 0, -1);

        set_directed(20, 23, 1'b0);
        run_capture(0, 4, 0, 3);
        set_directed(25, 26, 1'b0);
        run_capture(0, 4, 0, -1);

        set_directed(20, 23, 1'b0);
        run_capture(0, 4, 1, -1);

        for (int r = 0; r < 6; r++) begin
            set_random();
            rmode[r % 2] = 2;
            run_capture(r % 2, (r % 2 == 0) ? 4 : 0, 2, -1);
            rmode[r % 2] = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
